// File: rtl/jericalla_instr_feeder.sv
// Instruction sequencer for the Jericalla_Evolution core: a host-loaded program RAM
// issued one word per accepted cycle over a valid/ready handshake.
module jericalla_instr_feeder #(
  parameter int IW    = 17,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [IW-1:0] ld_data,
  input  logic [LW-1:0] prog_len,
  input  logic          start,
  input  logic          abort,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  input  logic          core_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_mem [DEPTH];
  logic [LW-1:0] r_len;
  logic [IW-1:0] r_instr;
  logic          r_valid;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_stall;

  logic          w_ld_ok;
  logic          w_xfer;
  logic          w_last;
  logic [LW-1:0] w_len_eff;

  // Requests longer than the RAM are clipped so the pc can never wrap.
  assign w_len_eff = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign w_ld_ok   = ld_en && (r_state != S_RUN);
  assign w_xfer    = r_valid && core_ready;
  assign w_last    = ({1'b0, r_pc} == (r_len - 1'b1));

  // NOTE: program storage has no reset; contents survive RST so a program can be rerun.
  always_ff @(posedge CLK) begin
    if (w_ld_ok) r_mem[ld_addr] <= ld_data;
  end

  // NOTE: all state and outputs use non-blocking assignments so every register
  // updates from the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_stall <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (r_state == S_DONE && abort) begin
            r_state <= S_IDLE;
          end else if (start && !ld_en) begin
            r_len   <= w_len_eff;
            r_pc    <= '0;
            r_stall <= '0;
            if (w_len_eff == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
              r_instr <= r_mem[0];
              r_valid <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_pc    <= '0;
          end else if (w_xfer) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_pc    <= r_pc + 1'b1;
              r_instr <= r_mem[r_pc + 1'b1];
            end
          end else if (r_valid && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign stall_cnt   = r_stall;

endmodule

// File: doc/jericalla_instr_feeder.md
Name: jericalla_instr_feeder

Overview:
Instruction sequencer that drives 17-bit instructions into the Jericalla_Evolution core. Host preloads a small program RAM, pulses start, and the block issues one instruction per accepted cycle through a valid/ready handshake, tracking PC, stalls and completion. It replaces bench-driven instruction stimulus and sits directly in front of the core's instruction input.

Parameters:
IW, 17, instruction width; matches core instruction port
DEPTH, 16, program RAM entries (power of 2, >=2)
AW, $clog2(DEPTH), RAM address width
LW, AW+1, prog_len width (encodes 0..DEPTH)

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous active-high reset
ld_en  input  1  program RAM write strobe
ld_addr  input  AW  write address
ld_data  input  IW  instruction word to store
prog_len  input  LW  number of instructions to issue, sampled on start
start  input  1  begin issue from address 0
abort  input  1  stop issue, return to IDLE
instruction  output  IW  instruction to core (registered)
instr_valid  output  1  instruction holds a valid word
core_ready  input  1  core accepts instruction this cycle
pc  output  AW  address of word on instruction
busy  output  1  high in RUN
done  output  1  high in DONE until next start/abort/reset
stall_cnt  output  16  cycles with instr_valid=1 and core_ready=0, saturating

Behaviour:
- Reset (RST=1 at edge): state IDLE; instruction=0, instr_valid=0, pc=0, busy=0, done=0, stall_cnt=0. RAM contents not reset. Reset mid-RUN aborts immediately, no further issue.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- Load: ld_en in IDLE or DONE writes mem[ld_addr]<=ld_data at edge. ld_en in RUN ignored (RAM untouched).
- len_eff = min(prog_len, DEPTH), latched on start into internal len register.
- IDLE/DONE + start (ld_en=0): if len_eff==0 -> DONE, instr_valid stays 0. Else -> RUN at that edge with pc<=0, instruction<=mem[0], instr_valid<=1, stall_cnt<=0, done cleared. Latency: first word visible 1 cycle after start sampled.
- ld_en and start in same cycle: write performed, start ignored.
- RUN, transfer = instr_valid & core_ready:
  - transfer and pc==len-1: instr_valid<=0, state DONE; instruction holds last value.
  - transfer and pc<len-1: pc<=pc+1, instruction<=mem[pc+1], instr_valid stays 1 (back-to-back issue, one word per cycle with core_ready held high).
  - no transfer: instruction, pc, instr_valid held stable (no change while valid & !ready); stall_cnt<=stall_cnt+1 saturating at 16'hFFFF.
- start in RUN ignored. abort in RUN -> IDLE next edge, instr_valid<=0, pc<=0, done=0; abort wins over transfer in same cycle. abort in DONE -> IDLE. abort in IDLE no effect.
- pc never wraps: last issue at len-1 with len<=DEPTH; len==DEPTH issues addresses 0..DEPTH-1.
- stall_cnt retains value in DONE/IDLE until next start or reset.

Test Plan:
- Load mem[0..3]=17'h10C80,17'h09422,17'h11843,17'h180E4, prog_len=4, core_ready=1, pulse start -> instruction shows those 4 words on 4 consecutive cycles, pc 0,1,2,3, instr_valid high exactly 4 cycles, then done=1, busy=0, stall_cnt=0.
- Same program, core_ready low 3 cycles while pc=1 -> instruction held at 17'h09422, pc=1 during stall, stall_cnt=3, all 4 words still issued once each, in order.
- prog_len=0 start -> done=1 one cycle later, instr_valid never asserts; prog_len=20 (DEPTH=16) -> exactly 16 issues, pc ends at 15.
- abort at pc=2 in same cycle as core_ready=1 -> next cycle IDLE, instr_valid=0, pc=0, done=0, no further words; ld_en during RUN to addr 3 -> RAM unchanged (later rerun still issues 17'h180E4).
- ld_en+start same cycle in IDLE -> word written, no issue; start next cycle issues new word.
- Assert RST mid-RUN at pc=1 -> next cycle all outputs 0, state IDLE; restart without reload reproduces original sequence.
